// File: rtl/four_bit_fa.sv
`default_nettype none
// ============================================================================
//  Module      : four_bit_fa
//  Description : 4-bit ripple-carry adder built from four 1-bit full-adder
//                cells. The combinational sum/carry is always live, and an
//                optional registered copy is provided for clocked consumers.
//                Defining FOUR_BIT_FA_FLAGS_EN adds the signed-overflow and
//                zero flags, plus a registered copy of the overflow flag.
//  Revision    : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// 1-bit full-adder cell: one link of the ripple chain.
// ----------------------------------------------------------------------------
module four_bit_fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    logic w_prop;

    // Propagate term is shared by the sum bit and the carry-out.
    assign w_prop = a ^ b;
    assign s      = w_prop ^ c;
    assign co     = (a & b) | (c & w_prop);

endmodule

// ----------------------------------------------------------------------------
// Top level: ripple chain plus optional output register.
// ----------------------------------------------------------------------------
module four_bit_fa #(
    parameter int WIDTH   = 4,     // only 4 is a legal value
    parameter bit REG_OUT = 1'b1   // 1: build o_q/cout_q register, 0: tie off
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] o,
    output logic             cout,
    output logic [WIDTH-1:0] o_q,
    output logic             cout_q
`ifdef FOUR_BIT_FA_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero,
    output logic             ovf_q
`endif
);

    // w_carry[i] is the carry into bit i; w_carry[WIDTH] is the carry-out.
    logic [WIDTH:0] w_carry;

    assign w_carry[0] = cin;

    // One full-adder cell per bit; no input sanitising, so X/Z propagate.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bits
            four_bit_fa_cell u_cell (
                .a  (a[i]),
                .b  (b[i]),
                .c  (w_carry[i]),
                .s  (o[i]),
                .co (w_carry[i+1])
            );
        end
    endgenerate

    assign cout = w_carry[WIDTH];

`ifdef FOUR_BIT_FA_FLAGS_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    assign ovf  = w_carry[WIDTH] ^ w_carry[WIDTH-1];
    assign zero = (o == '0);
`endif

    generate
        if (REG_OUT) begin : g_reg_out
            logic [WIDTH-1:0] r_o;
            logic             r_cout;
`ifdef FOUR_BIT_FA_FLAGS_EN
            logic             r_ovf;
`endif

            // Capture the combinational result every edge; reset clears it at once.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_o    <= '0;
                    r_cout <= 1'b0;
`ifdef FOUR_BIT_FA_FLAGS_EN
                    r_ovf  <= 1'b0;
`endif
                end else begin
                    r_o    <= o;
                    r_cout <= cout;
`ifdef FOUR_BIT_FA_FLAGS_EN
                    r_ovf  <= ovf;
`endif
                end
            end

            assign o_q    = r_o;
            assign cout_q = r_cout;
`ifdef FOUR_BIT_FA_FLAGS_EN
            assign ovf_q  = r_ovf;
`endif
        end else begin : g_no_reg_out
            // Register not built: outputs held at zero.
            assign o_q    = '0;
            assign cout_q = 1'b0;
`ifdef FOUR_BIT_FA_FLAGS_EN
            assign ovf_q  = 1'b0;
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_four_bit_fa.sv
`default_nettype none
// ============================================================================
//  Module      : tb_four_bit_fa
//  Description : Scoreboard bench for four_bit_fa. Stimulus pushes expected
//                combinational and registered results into queues; monitors
//                pop and compare them against the DUT outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_four_bit_fa;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] o;
    logic       cout;
    logic [3:0] o_q;
    logic       cout_q;
`ifdef FOUR_BIT_FA_FLAGS_EN
    logic       ovf;
    logic       zero;
    logic       ovf_q;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected entry layout: [3:0] sum, [4] carry-out, [5] signed overflow, [6] zero.
    logic [6:0] comb_q[$];
    logic [6:0] reg_q[$];

    four_bit_fa #(
        .WIDTH   (4),
        .REG_OUT (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .o      (o),
        .cout   (cout),
        .o_q    (o_q),
        .cout_q (cout_q)
`ifdef FOUR_BIT_FA_FLAGS_EN
        ,
        .ovf    (ovf),
        .zero   (zero),
        .ovf_q  (ovf_q)
`endif
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain unsigned and signed arithmetic.
    function automatic logic [6:0] model(input int ua, input int ub, input int uc);
        int s;
        int sa;
        int sb;
        int ss;
        logic [6:0] r;
        s  = ua + ub + uc;
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        ss = sa + sb + uc;
        r[3:0] = 4'(s % 16);
        r[4]   = (s >= 16);
        r[5]   = (ss > 7) || (ss < -8);
        r[6]   = ((s % 16) == 0);
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one vector just after a rising edge and queue its expectations.
    task automatic apply(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc);
        logic [6:0] e;
        @(posedge clk);
        #2;
        a   = ta;
        b   = tb_v;
        cin = tc;
        e   = model(int'(ta), int'(tb_v), int'(tc));
        comb_q.push_back(e);
        reg_q.push_back(e);
    endtask

    // Combinational monitor: mid-cycle, inputs settled since posedge+2.
    always @(negedge clk) begin
        logic [6:0] e;
        if (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            check("comb_sum", 8'({cout, o}), 8'(e[4:0]));
`ifdef FOUR_BIT_FA_FLAGS_EN
            check("comb_ovf",  8'(ovf),  8'(e[5]));
            check("comb_zero", 8'(zero), 8'(e[6]));
`endif
        end
    end

    // Registered monitor: just after the edge that loaded the queued vector.
    always @(posedge clk) begin
        logic [6:0] e;
        #1;
        if (reg_q.size() > 0) begin
            e = reg_q.pop_front();
            check("reg_sum", 8'({cout_q, o_q}), 8'(e[4:0]));
`ifdef FOUR_BIT_FA_FLAGS_EN
            check("reg_ovf", 8'(ovf_q), 8'(e[5]));
`endif
        end
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence.
    initial begin
        rst = 1'b1;
        a   = 4'd0;
        b   = 4'd0;
        cin = 1'b0;

        // Reset state, sampled after an edge with reset held.
        #7;
        check("reset_o_q",    8'(o_q),    8'd0);
        check("reset_cout_q", 8'(cout_q), 8'd0);
        #5;
        rst = 1'b0;

        // Sweep b with a=0, cin=0: o tracks b, no carry.
        for (logic [4:0] k = 5'd0; k < 5'd16; k++)
            apply(4'd0, k[3:0], 1'b0);

        // Carry chain and maximum input.
        apply(4'd15, 4'd1, 1'b0);
        apply(4'd15, 4'd1, 1'b1);
        apply(4'd15, 4'd15, 1'b1);

        // Flag corner vectors (sum checked in every build).
        apply(4'd7, 4'd1, 1'b0);
        apply(4'd8, 4'd8, 1'b0);

        // Asynchronous reset between edges with a=5, b=6.
        apply(4'd5, 4'd6, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_o_q",    8'(o_q),         8'd0);
        check("async_rst_cout_q", 8'(cout_q),      8'd0);
        check("async_rst_comb",   8'({cout, o}),   8'd11);
        #1;
        rst = 1'b0;
        reg_q.push_back(model(5, 6, 0));

        // Exhaustive sweep of all 512 input combinations.
        for (int v = 0; v < 512; v++)
            apply(4'(v >> 5), 4'(v >> 1), v[0]);

        // Randomised vectors.
        for (int n = 0; n < 200; n++)
            apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));

        // Let monitors drain, then confirm nothing was left unchecked.
        repeat (3) @(posedge clk);
        #3;
        check("comb_q_drained", 8'(comb_q.size()), 8'd0);
        check("reg_q_drained",  8'(reg_q.size()),  8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
